seq_rca: RTL and testbench



---
 rtl/seq_rca.sv | 104 ++++++++++
 tb/tb_seq_rca.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_rca.sv
// Multi-cycle add/subtract unit: an N-bit result is built K bits per clock
// through one K-bit ripple slice, with a start/done handshake.
module seq_rca #(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         c,
    output logic         ovf,
    output logic         busy,
    output logic         done
);
    // state | meaning
    // IDLE  | waiting for start; s/c/ovf hold the last result
    // RUN   | one K-bit chunk per edge, LSB chunk first
    // DONE  | result valid, done pulses for this cycle only

    localparam int CHUNKS = N / K;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    generate
        if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
            $error("seq_rca: illegal N/K combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic          cy;
    logic [K-1:0]  a_k;
    logic [K-1:0]  b_k;
    logic [K:0]    slice;

    always_comb begin
        a_k   = a_r[cnt*K +: K];
        b_k   = b_r[cnt*K +: K];
        slice = {1'b0, a_k} + {1'b0, b_k} + {{K{1'b0}}, cy};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            cy    <= 1'b0;
            s     <= '0;
            c     <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // subtract is a + ~b + ~borrow, so invert once here
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        cy    <= sub ? ~cin : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s[cnt*K +: K] <= slice[K-1:0];
                    cy            <= slice[K];
                    if (cnt == LAST) begin
                        c     <= slice[K];
                        ovf   <= (a_r[N-1] == b_r[N-1]) && (slice[K-1] != a_r[N-1]);
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_rca.sv
// Bench for seq_rca: five parameterisations share one stimulus stream and are
// compared against an integer-arithmetic reference model.
module tb_seq_rca;

    localparam int NN[5] = '{8, 8, 8, 16, 32};
    localparam int KK[5] = '{2, 8, 1, 4, 8};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;

    logic [7:0]  s0, s1, s2;
    logic [15:0] s3;
    logic [31:0] s4;
    logic [31:0] s_o[5];
    logic [4:0]  c_o, ovf_o, busy_o, done_o;

    int errors = 0;
    int checks = 0;

    int          lat[5];
    int          nd[5];
    logic [31:0] rs[5];
    logic        rc[5];
    logic        ro[5];

    always #5 clk = ~clk;

    seq_rca #(.N(8), .K(2)) u0 (.clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a32[7:0]), .b(b32[7:0]), .cin(cin), .s(s0), .c(c_o[0]), .ovf(ovf_o[0]),
        .busy(busy_o[0]), .done(done_o[0]));
    seq_rca #(.N(8), .K(8)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a32[7:0]), .b(b32[7:0]), .cin(cin), .s(s1), .c(c_o[1]), .ovf(ovf_o[1]),
        .busy(busy_o[1]), .done(done_o[1]));
    seq_rca #(.N(8), .K(1)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a32[7:0]), .b(b32[7:0]), .cin(cin), .s(s2), .c(c_o[2]), .ovf(ovf_o[2]),
        .busy(busy_o[2]), .done(done_o[2]));
    seq_rca #(.N(16), .K(4)) u3 (.clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a32[15:0]), .b(b32[15:0]), .cin(cin), .s(s3), .c(c_o[3]), .ovf(ovf_o[3]),
        .busy(busy_o[3]), .done(done_o[3]));
    seq_rca #(.N(32), .K(8)) u4 (.clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a32), .b(b32), .cin(cin), .s(s4), .c(c_o[4]), .ovf(ovf_o[4]),
        .busy(busy_o[4]), .done(done_o[4]));

    always_comb begin
        s_o[0] = {24'd0, s0};
        s_o[1] = {24'd0, s1};
        s_o[2] = {24'd0, s2};
        s_o[3] = {16'd0, s3};
        s_o[4] = s4;
    end

    // Reference: exact integer result, reduced modulo 2^n; overflow means the
    // true signed result does not fit in n bits. Returns {ovf, c, s}.
    function automatic logic [33:0] model(input int n, input logic [31:0] a, input logic [31:0] b,
                                          input logic sb_mode, input logic ci_bit);
        longint lim, ua, ub, sa, sb, ci, full, sr;
        logic [31:0] r;
        logic cf, of;
        lim = longint'(1) << n;
        ua  = longint'({32'd0, a}) & (lim - 1);
        ub  = longint'({32'd0, b}) & (lim - 1);
        sa  = (ua >= lim / 2) ? ua - lim : ua;
        sb  = (ub >= lim / 2) ? ub - lim : ub;
        ci  = ci_bit ? 1 : 0;
        if (!sb_mode) begin
            full = ua + ub + ci;
            cf   = (full >= lim);
            sr   = sa + sb + ci;
        end else begin
            full = ua - ub - ci;
            cf   = (ua >= ub + ci);
            sr   = sa - sb - ci;
        end
        r  = 32'(full & (lim - 1));
        of = (sr >= lim / 2) || (sr < -(lim / 2));
        return {of, cf, r};
    endfunction

    // Watches 12 edges starting with the start edge (edge 1) and records, per
    // instance, the edge number of done, the number of done cycles and the result.
    task automatic collect();
        for (int i = 0; i < 5; i++) begin
            lat[i] = 0;
            nd[i]  = 0;
        end
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) start = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (done_o[i]) begin
                    nd[i]++;
                    if (lat[i] == 0) lat[i] = e;
                    rs[i] = s_o[i];
                    rc[i] = c_o[i];
                    ro[i] = ovf_o[i];
                end
            end
        end
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv, input logic cv);
        @(negedge clk);
        a32   = av;
        b32   = bv;
        sub   = sv;
        cin   = cv;
        start = 1'b1;
        collect();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o != 5'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_o != 5'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b required 00000 within 50 cycles", busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_o[0] !== 32'd0 || c_o !== 5'b0 || ovf_o !== 5'b0 || busy_o !== 5'b0 || done_o !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: s=%h c=%b ovf=%b busy=%b done=%b required all zero",
                     s_o[0], c_o, ovf_o, busy_o, done_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sb;
        logic       ci;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    task automatic test_directed();
        vec_t dv[6];
        dv[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        dv[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        dv[2] = '{8'h7F, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
        dv[3] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
        dv[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        dv[5] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        for (int v = 0; v < 6; v++) begin
            run_op({24'd0, dv[v].a}, {24'd0, dv[v].b}, dv[v].sb, dv[v].ci);
            checks++;
            if (nd[0] != 1 || lat[0] != 5) begin
                errors++;
                $display("FAIL directed_timing[%0d]: done_cycles=%0d edge=%0d required 1 and 5", v, nd[0], lat[0]);
            end
            checks++;
            if (rs[0][7:0] !== dv[v].s || rc[0] !== dv[v].c || ro[0] !== dv[v].o) begin
                errors++;
                $display("FAIL directed[%0d]: s=%h c=%b ovf=%b required s=%h c=%b ovf=%b",
                         v, rs[0][7:0], rc[0], ro[0], dv[v].s, dv[v].c, dv[v].o);
            end
        end
        wait_idle();
    endtask

    task automatic test_ignore_start();
        int l, n;
        logic [7:0] r;
        logic rcv, rov;
        l = 0;
        n = 0;
        r = '0;
        rcv = 1'b0;
        rov = 1'b0;
        @(negedge clk);
        a32 = 32'h5A; b32 = 32'h3C; sub = 1'b0; cin = 1'b0; start = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (done_o[0]) begin
                n++;
                if (l == 0) l = e;
                r = s0; rcv = c_o[0]; rov = ovf_o[0];
            end
            @(negedge clk);
            if (busy_o[0]) begin
                start = 1'b1;
                a32 = $urandom; b32 = $urandom; sub = 1'($urandom); cin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (n != 1 || l != 5) begin
            errors++;
            $display("FAIL ignore_start_timing: done_cycles=%0d edge=%0d required 1 and 5", n, l);
        end
        checks++;
        if (r !== 8'h96 || rcv !== 1'b0 || rov !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start_result: s=%h c=%b ovf=%b required 96 0 1", r, rcv, rov);
        end
        checks++;
        if (s0 !== 8'h96) begin
            errors++;
            $display("FAIL ignore_start_hold: s=%h required 96", s0);
        end
        wait_idle();
    endtask

    task automatic test_continuous_start();
        int last, n;
        last = -1;
        n = 0;
        @(negedge clk);
        a32 = 32'h12; b32 = 32'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done_o[0]) begin
                n++;
                checks++;
                if (s0 !== 8'h46) begin
                    errors++;
                    $display("FAIL continuous_result: s=%h required 46", s0);
                end
                if (last >= 0) begin
                    checks++;
                    if (e - last != 6) begin
                        errors++;
                        $display("FAIL continuous_interval: %0d cycles required 6", e - last);
                    end
                end
                last = e;
            end
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL continuous_count: %0d done pulses in 40 edges required 6", n);
        end
        wait_idle();
    endtask

    task automatic test_reset_midop();
        logic [33:0] m;
        int dseen;
        dseen = 0;
        @(negedge clk);
        a32 = 32'hA5C3_5A3C; b32 = 32'h1234_5678; sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (s_o[0] !== 32'd0 || c_o !== 5'b0 || ovf_o !== 5'b0 || busy_o !== 5'b0 || done_o !== 5'b0) begin
            errors++;
            $display("FAIL reset_midop_async: s=%h c=%b ovf=%b busy=%b done=%b required all zero",
                     s_o[0], c_o, ovf_o, busy_o, done_o);
        end
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
            if (done_o != 5'b0) dseen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            if (done_o != 5'b0) dseen++;
        end
        checks++;
        if (dseen != 0) begin
            errors++;
            $display("FAIL reset_midop_nodone: %0d done cycles required 0", dseen);
        end
        run_op(32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            m = model(NN[i], 32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0);
            checks++;
            if (nd[i] != 1 || rs[i] !== m[31:0] || rc[i] !== m[32] || ro[i] !== m[33]) begin
                errors++;
                $display("FAIL reset_recover[%0d]: done=%0d s=%h c=%b ovf=%b required 1 %h %b %b",
                         i, nd[i], rs[i], rc[i], ro[i], m[31:0], m[32], m[33]);
            end
        end
        wait_idle();
    endtask

    task automatic test_sweep();
        logic [31:0] av, bv;
        logic sv, cv;
        logic [33:0] m;
        for (int t = 0; t < 1000; t++) begin
            av = $urandom;
            bv = $urandom;
            sv = 1'($urandom);
            cv = 1'($urandom);
            run_op(av, bv, sv, cv);
            for (int i = 0; i < 5; i++) begin
                m = model(NN[i], av, bv, sv, cv);
                checks++;
                if (nd[i] != 1 || lat[i] != NN[i] / KK[i] + 1) begin
                    errors++;
                    $display("FAIL sweep_timing N=%0d K=%0d: done_cycles=%0d edge=%0d required 1 and %0d",
                             NN[i], KK[i], nd[i], lat[i], NN[i] / KK[i] + 1);
                end
                checks++;
                if (rs[i] !== m[31:0]) begin
                    errors++;
                    $display("FAIL sweep_s N=%0d K=%0d a=%h b=%h sub=%b cin=%b: s=%h required %h",
                             NN[i], KK[i], av, bv, sv, cv, rs[i], m[31:0]);
                end
                checks++;
                if (rc[i] !== m[32] || ro[i] !== m[33]) begin
                    errors++;
                    $display("FAIL sweep_flags N=%0d K=%0d a=%h b=%h sub=%b cin=%b: c=%b ovf=%b required %b %b",
                             NN[i], KK[i], av, bv, sv, cv, rc[i], ro[i], m[32], m[33]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_continuous_start();
        test_reset_midop();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
